// File: rtl/mult_operand_queue.sv
// Operand-pair FIFO feeding a shift-add multiplier: issues one {A,B} pair per multiplier handshake.
// Optional build macro MULT_OPQ_ISSUE_COUNT_EN adds a 16-bit wrapping issue counter output issued_cnt.
module mult_operand_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GUARD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [7:0]                in_A,
  input  logic [7:0]                in_B,
  output logic                      in_ready,
  output logic                      start,
  output logic [7:0]                A,
  output logic [7:0]                B,
  input  logic                      mult_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
`ifdef MULT_OPQ_ISSUE_COUNT_EN
  ,
  output logic [15:0]               issued_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [GW-1:0] r_guard;
  state_t        r_state;

  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_head;

  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign in_ready = !full;

  // A pop is the IDLE->ISSUE transition; a push is never bypassed to the output.
  assign w_push = in_valid && !full;
  assign w_pop  = (r_state == IDLE) && !empty && mult_ready;
  assign w_head = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= {in_A, in_B};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: WAIT ignores mult_ready until the guard counter has drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_guard <= '0;
      start   <= 1'b0;
      A       <= 8'h00;
      B       <= 8'h00;
    end else begin
      start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            A       <= w_head[15:8];
            B       <= w_head[7:0];
            start   <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_guard <= GW'(GUARD);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_guard != '0) begin
            r_guard <= r_guard - GW'(1);
          end else if (mult_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MULT_OPQ_ISSUE_COUNT_EN
  logic [15:0] r_issued;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued <= 16'h0000;
    end else if (w_pop) begin
      r_issued <= r_issued + 16'd1;
    end
  end

  assign issued_cnt = r_issued;
`endif

endmodule

// File: tb/tb_mult_operand_queue.sv
// Directed bench for mult_operand_queue (DEPTH=4, GUARD=2); issued_cnt checked when MULT_OPQ_ISSUE_COUNT_EN is set.
module tb_mult_operand_queue;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_ready;
  logic       start;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic       mult_ready;
  logic [2:0] count;
  logic       empty;
  logic       full;
`ifdef MULT_OPQ_ISSUE_COUNT_EN
  logic [15:0] issued_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  mult_operand_queue #(.DEPTH(4), .GUARD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_A       (in_a),
    .in_B       (in_b),
    .in_ready   (in_ready),
    .start      (start),
    .A          (a_out),
    .B          (b_out),
    .mult_ready (mult_ready),
    .count      (count),
    .empty      (empty),
    .full       (full)
`ifdef MULT_OPQ_ISSUE_COUNT_EN
    ,
    .issued_cnt (issued_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  // Steps until start is seen; n is the number of edges taken.
  task automatic wait_start(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (start !== 1'b1 && n < budget);
    chk("start_seen", 32'(start), 32'd1);
  endtask

  task automatic no_start(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (start === 1'b1) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  logic [7:0] fill_a [4];
  logic [7:0] fill_b [4];
  int         n;
  logic [7:0] ra;
  logic [7:0] rb;

  initial begin
    fill_a[0] = 8'h10; fill_b[0] = 8'h11;
    fill_a[1] = 8'h20; fill_b[1] = 8'h21;
    fill_a[2] = 8'h30; fill_b[2] = 8'h31;
    fill_a[3] = 8'h40; fill_b[3] = 8'h41;

    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; mult_ready = 1'b0;
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_A", 32'(a_out), 32'd0);
    chk("rst_B", 32'(b_out), 32'd0);
`ifdef MULT_OPQ_ISSUE_COUNT_EN
    chk("rst_issued", 32'(issued_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Single op: start one edge after the push, held for exactly one cycle.
    mult_ready = 1'b1;
    push(8'h0C, 8'h0B);
    chk("t1_no_bypass", 32'(start), 32'd0);
    chk("t1_count_push", 32'(count), 32'd1);
    step();
    chk("t1_start", 32'(start), 32'd1);
    chk("t1_A", 32'(a_out), 32'h0C);
    chk("t1_B", 32'(b_out), 32'h0B);
    chk("t1_product", 32'(16'(a_out) * 16'(b_out)), 32'h0084);
    chk("t1_count_pop", 32'(count), 32'd0);
    step();
    chk("t1_start_one_cycle", 32'(start), 32'd0);
    chk("t1_A_hold", 32'(a_out), 32'h0C);
    step(); step(); step();
    mult_ready = 1'b0;

    // Fill to DEPTH with the multiplier busy; the fifth pair is dropped.
    for (int i = 0; i < 4; i++) push(fill_a[i], fill_b[i]);
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    push(8'hFF, 8'hFF);
    chk("t2_drop_count", 32'(count), 32'd4);
    mult_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(20, n);
      chk("t2_gap", 32'(n), (i == 0) ? 32'd1 : 32'd5);
      chk("t2_A", 32'(a_out), 32'(fill_a[i]));
      chk("t2_B", 32'(b_out), 32'(fill_b[i]));
    end
    chk("t2_empty", 32'(empty), 32'd1);
    step(); step(); step(); step();
    mult_ready = 1'b0;

    // Ordering, with mult_ready ignored until the guard window ends.
    push(8'h01, 8'h02);
    push(8'h03, 8'h04);
    push(8'h05, 8'h06);
    mult_ready = 1'b1;
    wait_start(20, n);
    chk("t3_gap0", 32'(n), 32'd1);
    chk("t3_A0", 32'(a_out), 32'h01);
    chk("t3_B0", 32'(b_out), 32'h02);
    mult_ready = 1'b0;
    no_start("t3_hold_while_busy", 6);
    mult_ready = 1'b1;
    wait_start(20, n);
    chk("t3_gap1", 32'(n), 32'd2);
    chk("t3_A1", 32'(a_out), 32'h03);
    chk("t3_B1", 32'(b_out), 32'h04);
    wait_start(20, n);
    chk("t3_gap2", 32'(n), 32'd5);
    chk("t3_A2", 32'(a_out), 32'h05);
    chk("t3_B2", 32'(b_out), 32'h06);
    step(); step(); step(); step();
    mult_ready = 1'b0;

    // Simultaneous push and pop at count=2; pointers have wrapped by now.
    push(8'h50, 8'h51);
    push(8'h60, 8'h61);
    chk("t4_count_pre", 32'(count), 32'd2);
    mult_ready = 1'b1;
    push(8'h70, 8'h71);
    chk("t4_start", 32'(start), 32'd1);
    chk("t4_A", 32'(a_out), 32'h50);
    chk("t4_count_pushpop", 32'(count), 32'd2);
    wait_start(20, n);
    chk("t4_gap1", 32'(n), 32'd5);
    chk("t4_A1", 32'(a_out), 32'h60);
    chk("t4_B1", 32'(b_out), 32'h61);
    wait_start(20, n);
    chk("t4_A2", 32'(a_out), 32'h70);
    chk("t4_B2", 32'(b_out), 32'h71);
    chk("t4_count_end", 32'(count), 32'd0);
    mult_ready = 1'b0;

    // Reset while parked in WAIT holding three pairs.
    push(8'hA1, 8'hA2);
    push(8'hB1, 8'hB2);
    push(8'hC1, 8'hC2);
    chk("t5_count_pre", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    chk("t5_count_async", 32'(count), 32'd0);
    chk("t5_empty_async", 32'(empty), 32'd1);
    chk("t5_start_async", 32'(start), 32'd0);
    chk("t5_A_async", 32'(a_out), 32'd0);
    step();
    rst = 1'b0;
    mult_ready = 1'b1;
    no_start("t5_no_start_after_rst", 8);
    chk("t5_count_post", 32'(count), 32'd0);
    push(8'h0C, 8'h0B);
    wait_start(20, n);
    chk("t5_restart_gap", 32'(n), 32'd1);
    chk("t5_restart_A", 32'(a_out), 32'h0C);

    // 100 random ops from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
`ifdef MULT_OPQ_ISSUE_COUNT_EN
    chk("t6_issued_rst", 32'(issued_cnt), 32'd0);
`endif
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      push(ra, rb);
      wait_start(20, n);
      chk("t6_A", 32'(a_out), 32'(ra));
      chk("t6_B", 32'(b_out), 32'(rb));
      chk("t6_product", 32'(16'(a_out) * 16'(b_out)), 32'(16'(ra) * 16'(rb)));
    end
    chk("t6_empty", 32'(empty), 32'd1);
`ifdef MULT_OPQ_ISSUE_COUNT_EN
    chk("t6_issued", 32'(issued_cnt), 32'd100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_operand_queue.md
MULT_OPERAND_QUEUE -- requirements
Module: mult_operand_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter GUARD, default 2, cycles after start during which mult_ready is ignored.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, upstream offers an operand pair.
REQ-006 SHALL have port in_A, input, 8, multiplicand.
REQ-007 SHALL have port in_B, input, 8, multiplier.
REQ-008 SHALL have port in_ready, output, 1, queue accepts a pair this cycle.
REQ-009 SHALL have port start, output, 1, issue strobe to the shift-add multiplier.
REQ-010 SHALL have port A, output, 8, operand A to the multiplier.
REQ-011 SHALL have port B, output, 8, operand B to the multiplier.
REQ-012 SHALL have port mult_ready, input, 1, multiplier done/idle.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-014 SHALL have port empty, output, 1, count==0.
REQ-015 SHALL have port full, output, 1, count==DEPTH.

Function
REQ-016 SHALL store pairs {in_A,in_B} in a circular FIFO with wr/rd pointers wrapping modulo DEPTH.
REQ-017 SHALL drive in_ready = !full combinationally from current occupancy; a push occurs on a rising edge with in_valid && in_ready.
REQ-018 SHALL reject a push when full even if a pop happens in the same cycle; in_valid while full is ignored with no state change.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-020 SHALL transition IDLE->ISSUE when !empty && mult_ready; on that edge register head into A/B, set start=1, advance rd pointer.
REQ-021 SHALL hold start high exactly one cycle (ISSUE); ISSUE->WAIT unconditionally, start cleared.
REQ-022 SHALL stay in WAIT for GUARD cycles ignoring mult_ready, then return WAIT->IDLE on the first cycle mult_ready=1.
REQ-023 SHALL hold A/B at the last issued values outside ISSUE (never X after first issue).
REQ-024 SHALL, for a push at edge k into an empty queue with FSM in IDLE and mult_ready=1, raise start after edge k+1 (no same-cycle bypass).
REQ-025 SHALL update count by +1 push only, -1 pop only, unchanged for push+pop in one cycle.
REQ-026 SHALL allow back-to-back operations: IDLE with mult_ready=1 and !empty issues with no extra idle cycle.

Reset
REQ-027 SHALL on rst=1 immediately clear pointers, count=0, empty=1, full=0, in_ready=1, start=0, A=0, B=0, FSM=IDLE, guard counter=0.
REQ-028 SHALL on reset mid-operation discard queued pairs and any in-flight result; no start until a new push after rst deasserts.

Configuration
REQ-029 SHALL, with macro MULT_OPQ_ISSUE_COUNT_EN defined, add output issued_cnt, 16 bits, reset 0, incremented on every ISSUE entry, wrapping 0xFFFF->0x0000.
REQ-030 SHALL, without MULT_OPQ_ISSUE_COUNT_EN, omit issued_cnt and its logic; all other behaviour identical.

Verification
REQ-031 SHALL cover single op: push (0x0C,0x0B), mult_ready=1 -> start one cycle, A=0x0C, B=0x0B, downstream product 0x0084.
REQ-032 SHALL cover fill: 4 pushes with mult_ready=0 -> full=1, count=4, in_ready=0; 5th pair (0xFF,0xFF) dropped.
REQ-033 SHALL cover ordering: pushes (1,2),(3,4),(5,6) -> issues in same order, each start only after mult_ready returns high past GUARD.
REQ-034 SHALL cover push+pop while count=2 -> count stays 2; pointers wrap after 5+ pushes with data intact.
REQ-035 SHALL cover reset during WAIT with count=3 -> count=0, start=0, FSM IDLE, no further start.
REQ-036 SHALL cover MULT_OPQ_ISSUE_COUNT_EN defined, 100 random ops -> issued_cnt=100, all products match A*B.
